// File: rtl/tinyalu_param_if.sv
// Operation bus of the parametrised tiny ALU: request (start/A/B/op) from the host,
// status and result (busy/done/err/result) back from the unit.
interface tinyalu_param_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [2:0]           op;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output start, A, B, op,
        input  busy, done, err, result
    );

    modport slave (
        input  start, A, B, op,
        output busy, done, err, result
    );
endinterface

// File: rtl/tinyalu_param.sv
// Single-issue start/done ALU: WIDTH-bit unsigned operands, 2*WIDTH-bit result,
// one-cycle ADD/AND/XOR/SUB/NOP/illegal and MUL_LAT-cycle multiply with back-to-back issue.
module tinyalu_param #(
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    tinyalu_param_if.slave bus
);
    localparam int RW    = 2 * WIDTH;
    localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
    // WAIT is entered on the accept edge, so it spans MUL_LAT-1 edges; the last one sees this count.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;

    function automatic logic [RW-1:0] alu(input logic [2:0] op,
                                          input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
        logic [RW-1:0] ax;
        logic [RW-1:0] bx;
        ax = RW'(a);
        bx = RW'(b);
        case (op)
            OP_ADD:  return ax + bx;
            OP_AND:  return ax & bx;
            OP_XOR:  return ax ^ bx;
            OP_MUL:  return ax * bx;
            OP_SUB:  return ax - bx;
            default: return '0;
        endcase
    endfunction

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                accept = bus.start;
                if (!bus.start)
                    state_d = IDLE;
                else if (bus.op == OP_MUL && MUL_LAT > 1)
                    state_d = WAIT;
                else
                    state_d = DONE;
            end
            WAIT: begin
                if (cnt_q == CNT_LAST)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // NOTE: the operand registers are reset as well, so the decoded outputs are never X.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= OP_NOP;
            cnt_q <= '0;
        end else if (accept) begin
            a_q   <= bus.A;
            b_q   <= bus.B;
            op_q  <= bus.op;
            cnt_q <= '0;
        end else if (state_q == WAIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Outputs depend only on registered state and captured operands, never on live inputs.
    always_comb begin
        bus.busy   = (state_q == WAIT);
        bus.done   = (state_q == DONE);
        bus.err    = (state_q == DONE) && op_q[2] && op_q[1];
        bus.result = (state_q == DONE) ? alu(op_q, a_q, b_q) : '0;
    end
endmodule
